// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch port (read only)
//   and a data port (read/write). One transaction is in flight at a time:
//   IDLE (grant + latch) -> ACCESS (MEM_LAT cycles, mem_en high) -> RESP (ack).
//
// Parameters
//   MEM_LAT        memory access cycles per transaction (1..15)
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN  defined   : ties alternate between ports, first tie to DM
//                       undefined : ties always go to DM (fixed priority)
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and byte address
//   if_rdata/if_ack/if_stall        fetch read data, completion pulse, stall
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   data request fields
//   dm_rdata/dm_ack/dm_stall        data read data, completion pulse, stall
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata   shared memory port
module mem_port_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_stall,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        dm_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        owner_dm_q;     // owner of the active transaction: 1 = DM, 0 = IF
   logic        mem_en_q, mem_we_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [31:0] if_rdata_q, dm_rdata_q;
   logic        if_ack_q, dm_ack_q;

   // Tie-break: 1 means DM wins when both ports request in the same IDLE cycle.
   logic tie_dm;
`ifdef ARB_ROUND_ROBIN_EN
   logic last_dm_q;             // port granted last; resets to IF so first tie goes to DM
   assign tie_dm = ~last_dm_q;
`else
   assign tie_dm = 1'b1;
`endif

   logic        pick_dm_d;
   logic        req_we_d;
   logic [3:0]  req_be_d;
   logic [31:0] req_addr_d, req_wdata_d;

   // Fetch requests are presented to memory as full-word reads.
   assign pick_dm_d   = dm_req & (~if_req | tie_dm);
   assign req_we_d    = pick_dm_d & dm_we;
   assign req_be_d    = pick_dm_d ? dm_be    : 4'hF;
   assign req_addr_d  = pick_dm_d ? dm_addr  : if_addr;
   assign req_wdata_d = pick_dm_d ? dm_wdata : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'h0;
         owner_dm_q  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         if_rdata_q  <= 32'h0;
         dm_rdata_q  <= 32'h0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_dm_q   <= 1'b0;
`endif
      end else begin
         // acks are single-cycle pulses raised on the ACCESS->RESP transition
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_req | dm_req) begin
                  owner_dm_q  <= pick_dm_d;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= req_we_d;
                  mem_be_q    <= req_be_d;
                  mem_addr_q  <= req_addr_d;
                  mem_wdata_q <= req_wdata_d;
                  cnt_q       <= LAT_M1;
                  state_q     <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                  last_dm_q   <= pick_dm_d;
`endif
               end
            end
            ACCESS: begin
               if (cnt_q == 4'h0) begin
                  // last access cycle: read data is valid on mem_rdata now
                  if (!mem_we_q) begin
                     if (owner_dm_q) dm_rdata_q <= mem_rdata;
                     else            if_rdata_q <= mem_rdata;
                  end
                  if (owner_dm_q) dm_ack_q <= 1'b1;
                  else            if_ack_q <= 1'b1;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign dm_stall  = dm_req & ~dm_ack_q;

endmodule
